// File: rtl/polar_clip_mul_rr_sched.sv
// rtl/polar_clip_mul_rr_sched.sv - round-robin share of one 3-stage 25s x 9u multiplier among NUM_REQ requesters
// Optional per-requester grant and stall counters under POLAR_CLIP_RR_STATS_EN.

module polar_clip_mul_mul_25s_9ns_25_4_1 (
    input  logic        clk,
    input  logic        ce,
    input  logic [24:0] din0,
    input  logic [8:0]  din1,
    output logic [24:0] dout
);
    logic signed [24:0] a_q;
    logic        [8:0]  b_q;
    logic        [24:0] p_q;
    logic        [24:0] dout_q;
    logic signed [24:0] b_ext;
    logic signed [24:0] prod;

    // Only the low 25 bits survive, so the product is formed at that width.
    assign b_ext = {16'b0, b_q};
    assign prod  = a_q * b_ext;
    assign dout  = dout_q;

    always_ff @(posedge clk) begin
        if (ce) begin
            a_q    <= din0;
            b_q    <= din1;
            p_q    <= prod;
            dout_q <= p_q;
        end
    end
endmodule

module polar_clip_mul_rr_sched #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*25-1:0] req_a,
    input  logic [NUM_REQ*9-1:0]  req_b,
    output logic [NUM_REQ-1:0]    res_valid,
    input  logic [NUM_REQ-1:0]    res_ready,
    output logic [24:0]           res_p,
    input  logic                  drain_req,
    output logic                  drain_done,
    output logic                  busy
`ifdef POLAR_CLIP_RR_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0] stat_grants,
    output logic [31:0]           stat_stalls
`endif
);
    localparam int MUL_LAT = 3;
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_DRAINED = 2'd2;

    logic [1:0]                  state_q, state_d;
    logic [IDW-1:0]              ptr_q;
    logic [MUL_LAT-1:0]          vld_q;
    logic [MUL_LAT-1:0][IDW-1:0] id_q;

    logic           tail_vld;
    logic [IDW-1:0] tail_id;
    logic           ce;
    logic           found;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] cand;
    logic           issue;
    logic [24:0]    din0;
    logic [8:0]     din1;
    logic [24:0]    mul_dout;

    assign tail_vld = vld_q[MUL_LAT-1];
    assign tail_id  = id_q[MUL_LAT-1];
    assign ce       = !(tail_vld && !res_ready[tail_id]);

    // Search ptr+1, ptr+2, ... so the last winner has lowest priority.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                gnt_id = cand;
            end
        end
        issue = found && ce && (state_q == ST_RUN) && !drain_req && reset_n;
    end

    always_comb begin
        din0      = '0;
        din1      = '0;
        req_ready = '0;
        res_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                din0 = req_a[25*i +: 25];
                din1 = req_b[9*i +: 9];
            end
            req_ready[i] = issue && (gnt_id == IDW'(i));
            res_valid[i] = tail_vld && (tail_id == IDW'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (drain_req) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (vld_q == '0)     state_d = ST_DRAINED;
                else if (!drain_req) state_d = ST_RUN;
            end
            ST_DRAINED: if (!drain_req) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    assign res_p      = tail_vld ? mul_dout : '0;
    assign busy       = |vld_q;
    assign drain_done = (state_q == ST_DRAINED);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            ptr_q   <= IDW'(NUM_REQ - 1);
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            if (ce) begin
                vld_q <= {vld_q[MUL_LAT-2:0], issue};
                id_q  <= {id_q[MUL_LAT-2:0], gnt_id};
            end
            if (issue) ptr_q <= gnt_id;
        end
    end

    polar_clip_mul_mul_25s_9ns_25_4_1 u_mul (
        .clk  (clk),
        .ce   (ce),
        .din0 (din0),
        .din1 (din1),
        .dout (mul_dout)
    );

`ifdef POLAR_CLIP_RR_STATS_EN
    logic [31:0] grants_q [NUM_REQ];
    logic [31:0] stalls_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stalls_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) grants_q[i] <= '0;
        end else begin
            if (!ce && stalls_q != '1) stalls_q <= stalls_q + 32'd1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && grants_q[i] != '1) grants_q[i] <= grants_q[i] + 32'd1;
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NUM_REQ; i++) stat_grants[32*i +: 32] = grants_q[i];
    end
    assign stat_stalls = stalls_q;
`endif
endmodule
